// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC fetch front end: PC width, reset vector
// and the fetch sequencer state encoding.
package wisc_pkg;

   localparam int unsigned PC_W = 16;
   localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } pc_seq_state_t;

endpackage

// File: rtl/pc_seq_perf_cnt.sv
// Saturating up-counter with enable, used for fetch performance statistics.
module pc_seq_perf_cnt
   import wisc_pkg::*;
#(
   parameter int unsigned W = PC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (en && (cnt != '1))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: redirect/stall/wait/halt handling for instruction fetch.
// Optional performance counters are built when PC_SEQ_PERF_CNT_EN is defined.
module pc_sequencer
   import wisc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt_dec,
   input  logic            imem_rdy,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus2,
   output logic            imem_req,
   output logic            if_valid,
   output logic            if_id_flush,
   output logic            halted
`ifdef PC_SEQ_PERF_CNT_EN
   ,
   output logic [PC_W-1:0] br_taken_cnt,
   output logic [PC_W-1:0] stall_cnt
`endif
);

   pc_seq_state_t   state_q, state_d;
   logic [PC_W-1:0] pc_d;
   logic            drop_q, drop_d;
   logic [PC_W-1:0] target;

   assign target   = {redirect_pc[PC_W-1:1], 1'b0};
   assign pc_plus2 = pc + PC_W'(2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc      <= RESET_PC;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc      <= pc_d;
         drop_q  <= drop_d;
      end
   end

   // Next PC priority: redirect > stall > memory not ready > halt > sequential.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc;
      drop_d      = drop_q;
      imem_req    = 1'b0;
      if_valid    = 1'b0;
      if_id_flush = 1'b0;
      halted      = 1'b0;
      case (state_q)
         RUN, WAIT: begin
            imem_req = 1'b1;
            if (redirect_valid) begin
               pc_d        = target;
               if_id_flush = 1'b1;
               // A fetch for the old PC is still in flight; discard its beat.
               if (state_q == WAIT)
                  drop_d = 1'b1;
            end else if (stall) begin
               pc_d = pc;
            end else if (!imem_rdy) begin
               state_d = WAIT;
            end else if ((state_q == WAIT) && drop_q) begin
               drop_d = 1'b0;
            end else begin
               if_valid = 1'b1;
               if (halt_dec) begin
                  state_d = HALT;
               end else begin
                  state_d = RUN;
                  pc_d    = pc_plus2;
               end
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      if (rst) begin
         if_valid    = 1'b0;
         if_id_flush = 1'b0;
      end
   end

`ifdef PC_SEQ_PERF_CNT_EN
   logic active;
   assign active = (state_q != HALT);

   pc_seq_perf_cnt #(.W(PC_W)) u_br_cnt (
      .clk (clk),
      .rst (rst),
      .en  (active && redirect_valid),
      .cnt (br_taken_cnt)
   );

   pc_seq_perf_cnt #(.W(PC_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (active && stall),
      .cnt (stall_cnt)
   );
`else
   // Default build carries no performance counters.
`endif

endmodule
